logic_sweep_sequencer: RTL and testbench

//   Self-test sequencer for the 3-input gate cell (x = (A&B)|~C, y = ~C).
//   On start, drives all 8 input vectors {C,B,A} in ascending order and waits a settle period on each.
//   It then samples cell_x/cell_y and compares them against a golden model.

---
 rtl/logic_sweep_pkg.sv | 23 ++
 rtl/logic_sweep_golden.sv | 13 +
 rtl/logic_sweep_sequencer.sv | 123 ++++++++++++
 tb/tb_logic_sweep_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared types, constants and golden gate equations for the logic sweep self-test.
// The gate cell under test computes x = (A&B)|~C and y = ~C with vec = {C,B,A}.
package logic_sweep_pkg;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic exp_x(input logic [VEC_W-1:0] vec);
    return (vec[0] & vec[1]) | ~vec[2];
  endfunction

  function automatic logic exp_y(input logic [VEC_W-1:0] vec);
    return ~vec[2];
  endfunction

endpackage

// File: rtl/logic_sweep_golden.sv
// Combinational golden model of the gate cell: vector {C,B,A} -> expected x, y.
module logic_sweep_golden
  import logic_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             x,
  output logic             y
);

  assign x = exp_x(vec);
  assign y = exp_y(vec);

endmodule

// File: rtl/logic_sweep_sequencer.sv
// Self-test sequencer: sweeps all 8 cell input vectors, settles, samples the cell
// outputs against the golden model and reports error count, first failure and pass.
module logic_sweep_sequencer
  import logic_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cell_x,
  input  logic             cell_y,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [VEC_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  logic             gold_x;
  logic             gold_y;
  logic             mismatch;
  logic             err_sat;

  logic_sweep_golden u_golden (
    .vec (idx),
    .x   (gold_x),
    .y   (gold_y)
  );

  assign mismatch = (cell_x != gold_x) | (cell_y != gold_y);
  assign err_sat  = &err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      settle_cnt       <= '0;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state            <= DRIVE;
            idx              <= '0;
            settle_cnt       <= '0;
            vec_out          <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          // An aborted sample is discarded so the partial results stay consistent.
          if (abort) begin
            state   <= IDLE;
            vec_out <= '0;
            busy    <= 1'b0;
            pass    <= 1'b0;
          end else begin
            if (mismatch) begin
              if (!err_sat) err_count <= err_count + 1'b1;
              if (!first_fail_valid) begin
                first_fail_vec   <= idx;
                first_fail_valid <= 1'b1;
              end
            end
            if (idx == LAST_VEC) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              state      <= DRIVE;
              idx        <= idx + 1'b1;
              vec_out    <= idx + 1'b1;
              settle_cnt <= '0;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          vec_out <= '0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sweep_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed sweep results, a negedge monitor
// pops and compares them whenever a DUT raises done.
module tb_logic_sweep_sequencer;
  import logic_sweep_pkg::*;

  typedef struct {
    int cyc;
    int pass;
    int err;
    int ffvalid;
    int ffv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  int   fault_mode;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] vec1, vec2, ffv1, ffv2;
  logic       busy1, busy2, done1, done2, pass1, pass2, ffval1, ffval2;
  logic [3:0] err1;
  logic [1:0] err2;
  logic       gx1, gy1, gx2, gy2, cx1, cy1, cx2, cy2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell models: DUT1 has a selectable fault, DUT2 always has cell_y inverted.
  logic_sweep_golden g1 (.vec(vec1), .x(gx1), .y(gy1));
  logic_sweep_golden g2 (.vec(vec2), .x(gx2), .y(gy2));
  assign cx1 = (fault_mode == 1) ? 1'b0 : gx1;
  assign cy1 = (fault_mode == 2) ? ~gy1 : gy1;
  assign cx2 = gx2;
  assign cy2 = ~gy2;

  logic_sweep_sequencer #(.SETTLE_CYCLES(2), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cell_x(cx1), .cell_y(cy1), .vec_out(vec1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  logic_sweep_sequencer #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cell_x(cx2), .cell_y(cy2), .vec_out(vec2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_fail_vec(ffv2), .first_fail_valid(ffval2)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input int p, input int er, input int fv, input int f);
    exp_t e;
    e.cyc = c; e.pass = p; e.err = er; e.ffvalid = fv; e.ffv = f;
    return e;
  endfunction

  // Monitor: compares each done pulse against the oldest expected sweep result.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        $display("dut1 sweep done cycle=%0d pass=%0d err=%0d ffv=%0d ffvalid=%0d",
                 cyc, pass1, err1, ffv1, ffval1);
        chk("dut1_done_cycle", cyc, e1.cyc);
        chk("dut1_pass", int'(pass1), e1.pass);
        chk("dut1_err_count", int'(err1), e1.err);
        chk("dut1_ff_valid", int'(ffval1), e1.ffvalid);
        chk("dut1_ff_vec", int'(ffv1), e1.ffv);
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e2 = q2.pop_front();
        $display("dut2 sweep done cycle=%0d pass=%0d err=%0d ffv=%0d ffvalid=%0d",
                 cyc, pass2, err2, ffv2, ffval2);
        chk("dut2_done_cycle", cyc, e2.cyc);
        chk("dut2_pass", int'(pass2), e2.pass);
        chk("dut2_err_sat", int'(err2), e2.err);
        chk("dut2_ff_valid", int'(ffval2), e2.ffvalid);
        chk("dut2_ff_vec", int'(ffv2), e2.ffv);
      end
    end
  end

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending results, expected 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  // One start pulse; done expected in cycle 25 after the start-sampling edge.
  task automatic sweep(input int mode, input int err, input int ffvalid, input int ffv);
    @(negedge clk);
    fault_mode = mode;
    start = 1'b1;
    q1.push_back(mk(cyc + 25, (err == 0) ? 1 : 0, err, ffvalid, ffv));
    q2.push_back(mk(cyc + 25, 0, 3, 1, 0));
    @(negedge clk);
    start = 1'b0;
    wait_empty(60);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy1"}, int'(busy1), 0);
    chk({tag, "_vec1"}, int'(vec1), 0);
    chk({tag, "_pass1"}, int'(pass1), 0);
    chk({tag, "_err1"}, int'(err1), 0);
    chk({tag, "_ffvalid1"}, int'(ffval1), 0);
    chk({tag, "_ffv1"}, int'(ffv1), 0);
    chk({tag, "_done1"}, int'(done1), 0);
    chk({tag, "_busy2"}, int'(busy2), 0);
    chk({tag, "_err2"}, int'(err2), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fault_mode = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Golden cell, x stuck-0 (vecs 0,1,2,3,7), y inverted (all 8).
    sweep(0, 0, 0, 0);
    sweep(1, 5, 1, 0);
    sweep(2, 8, 1, 0);
    sweep(0, 0, 0, 0);

    // Abort during cycle 10: vecs 0..2 already sampled.
    @(negedge clk);
    fault_mode = 1; start = 1'b1; m = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < m + 10) @(negedge clk);
    chk("abort_busy_before", int'(busy1), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy1", int'(busy1), 0);
    chk("abort_vec1", int'(vec1), 0);
    chk("abort_pass1", int'(pass1), 0);
    chk("abort_err1", int'(err1), 3);
    chk("abort_ffvalid1", int'(ffval1), 1);
    chk("abort_ffv1", int'(ffv1), 0);
    chk("abort_err2", int'(err2), 3);
    repeat (30) @(negedge clk);
    chk("abort_hold_busy1", int'(busy1), 0);
    chk("abort_hold_err1", int'(err1), 3);

    // Reset in cycle 7 while two errors have accumulated.
    @(negedge clk);
    fault_mode = 1; start = 1'b1; m = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < m + 7) @(negedge clk);
    chk("prereset_err1", int'(err1), 2);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 0, 0, 0);

    // Start held high: back-to-back sweeps, second begins the IDLE cycle after DONE.
    @(negedge clk);
    fault_mode = 0; start = 1'b1; m = cyc;
    q1.push_back(mk(m + 25, 1, 0, 0, 0));
    q2.push_back(mk(m + 25, 0, 3, 1, 0));
    q1.push_back(mk(m + 51, 1, 0, 0, 0));
    q2.push_back(mk(m + 51, 0, 3, 1, 0));
    while (cyc < m + 51) @(negedge clk);
    start = 1'b0;
    wait_empty(10);

    // start together with abort in IDLE: no sweep.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("start_abort_busy1", int'(busy1), 0);
    end
    start = 1'b0; abort = 1'b0;
    repeat (30) @(negedge clk);
    chk("start_abort_pass_hold", int'(pass1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
